// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 active-low keypad scanner with row sync, debounce and encode.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] usrin,
  output logic       keyev
);

  localparam int c_dw = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_cw = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_dw-1:0] c_dwell_max = c_dw'(SCAN_DIV - 1);
  localparam logic [c_cw-1:0] c_cnt_max   = c_cw'(DEBOUNCE_SCANS);

  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [c_dw-1:0] r_dwell;
  logic [1:0]      r_col;
  logic [3:0]      r_raw;
  logic [3:0]      r_cand;
  logic [c_cw-1:0] r_cnt;
  logic [3:0]      r_usrin;
  logic            r_keyev;

  logic            w_sample;
  logic            w_eos;
  logic [3:0]      w_colcode;
  logic [3:0]      w_raw_next;
  logic [3:0]      w_cand_next;
  logic [c_cw-1:0] w_cnt_next;
  logic            w_accept;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd11;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd12;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd13;
      4'd12:   code = 4'd0;
      4'd13:   code = 4'd10;
      4'd14:   code = 4'd15;
      default: code = 4'd14;
    endcase
    return code;
  endfunction

  assign cols  = ~(4'b0001 << r_col);
  assign usrin = r_usrin;
  assign keyev = r_keyev;

  assign w_sample = (r_dwell == c_dwell_max);
  assign w_eos    = w_sample && (r_col == 2'd3);

  // Walk rows high to low so the lowest pressed, mapped row wins.
  always_comb begin
    w_colcode = 4'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_sync2[r] && (key_code(2'(r), r_col) != 4'd0)) begin
        w_colcode = key_code(2'(r), r_col);
      end
    end
  end

  always_comb begin
    w_raw_next  = r_raw;
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    if ((r_col == 2'd0) || (r_raw == 4'd0)) begin
      w_raw_next = w_colcode;
    end
    if (w_raw_next == r_cand) begin
      if (r_cnt != c_cnt_max) begin
        w_cnt_next = r_cnt + c_cw'(1);
      end
    end else begin
      w_cand_next = w_raw_next;
      w_cnt_next  = c_cw'(1);
    end
    w_accept = (w_cnt_next == c_cnt_max) && (w_cand_next != r_usrin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_dwell <= '0;
      r_col   <= 2'd0;
      r_raw   <= 4'd0;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_usrin <= 4'd0;
      r_keyev <= 1'b0;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
      r_keyev <= 1'b0;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 2'd1;
        r_raw   <= w_raw_next;
        if (w_eos) begin
          r_cand <= w_cand_next;
          r_cnt  <= w_cnt_next;
          if (w_accept) begin
            r_usrin <= w_cand_next;
            r_keyev <= (w_cand_next != 4'd0);
          end
        end
      end else begin
        r_dwell <= r_dwell + c_dw'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Brief    : Directed, table-driven bench for keypad_scan with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  usrin;
  logic        keyev;
  logic [15:0] mask = 16'h0000;

  int   checks = 0;
  int   errors = 0;
  int   consec = 0;
  logic kprev  = 1'b0;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    int          pulses;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .rst   (rst),
    .rows  (rows),
    .cols  (cols),
    .usrin (usrin),
    .keyev (keyev)
  );

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (keyev && kprev) consec++;
    kprev = keyev;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic window(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (keyev) pulses++;
    end
  endtask

  initial begin
    int          p;
    int          n;
    int          bad;
    int          rises;
    logic [3:0]  prev;
    logic [3:0]  e;

    vecs[0] = '{16'h2000, 4'd10, 1};  // row3/col1 digit '0'
    vecs[1] = '{16'h8000, 4'd14, 1};  // row3/col3
    vecs[2] = '{16'h4000, 4'd15, 1};  // row3/col2
    vecs[3] = '{16'h0008, 4'd11, 1};  // row0/col3
    vecs[4] = '{16'h1000, 4'd0,  0};  // '*' unmapped
    vecs[5] = '{16'h0040, 4'd6,  1};  // row1/col2
    vecs[6] = '{16'h0400, 4'd9,  1};  // row2/col2
    vecs[7] = '{16'h0012, 4'd4,  1};  // col0 beats col1
    vecs[8] = '{16'h3000, 4'd10, 1};  // '*' does not block col1

    @(negedge clk);
    do_reset(2);
    chk("reset_usrin", int'(usrin), 0);
    chk("reset_keyev", int'(keyev), 0);
    chk("scan_cols_c0", int'(cols), 4'b1110);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_cols", int'(cols), int'(e));
    end

    // Single press of '5' must be accepted within the worst-case latency.
    mask = 16'h0020;
    n = 0;
    p = 0;
    while (usrin != 4'd5 && n < 3*16+19) begin
      @(negedge clk);
      if (keyev) p++;
      n++;
    end
    chk("press5_usrin", int'(usrin), 5);
    window(20, n);
    chk("press5_keyev", p + n, 1);
    mask = 16'h0000;
    window(80, p);
    chk("release5_usrin", int'(usrin), 0);
    chk("release5_keyev", p, 0);

    for (int i = 0; i < 9; i++) begin
      mask = vecs[i].mask;
      window(80, p);
      chk("map_usrin", int'(usrin), int'(vecs[i].code));
      chk("map_keyev", p, vecs[i].pulses);
      mask = 16'h0000;
      window(80, p);
      chk("map_release_usrin", int'(usrin), 0);
      chk("map_release_keyev", p, 0);
    end

    // Two-scan-on / two-scan-off chatter never reaches the debounce count.
    bad = 0;
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      mask = (k % 2 == 0) ? 16'h0100 : 16'h0000;
      repeat (32) begin
        @(negedge clk);
        if (usrin != 4'd0) bad++;
        if (keyev) rises++;
      end
    end
    chk("chatter_usrin", bad, 0);
    chk("chatter_keyev", rises, 0);
    mask = 16'h0100;
    window(80, p);
    chk("chatter_hold_usrin", int'(usrin), 7);
    chk("chatter_hold_keyev", p, 1);
    mask = 16'h0000;
    window(80, p);

    // Fast bounce on '7': every accepted change is clean and ends on 7.
    bad = 0;
    rises = 0;
    p = 0;
    prev = usrin;
    for (int k = 0; k < 200; k++) begin
      if (k < 120 && (k % 7) == 0) mask = mask ^ 16'h0100;
      if (k == 120) mask = 16'h0100;
      @(negedge clk);
      if (keyev) p++;
      if (usrin != prev) begin
        if (prev == 4'd0 && usrin == 4'd7) rises++;
        else if (!(prev == 4'd7 && usrin == 4'd0)) bad++;
      end
      prev = usrin;
    end
    chk("bounce_usrin", int'(usrin), 7);
    chk("bounce_values", bad, 0);
    chk("bounce_keyev_per_accept", p, rises);
    mask = 16'h0000;
    window(80, p);

    // Simultaneous keys resolve by priority; releasing one rolls to the other.
    mask = 16'h0009;
    window(80, p);
    chk("simul_usrin", int'(usrin), 1);
    chk("simul_keyev", p, 1);
    mask = 16'h0008;
    window(80, p);
    chk("roll_usrin", int'(usrin), 11);
    chk("roll_keyev", p, 1);
    mask = 16'h0000;
    window(80, p);

    // Reset after two matching scans of '8' discards the debounce progress.
    mask = 16'h0200;
    do_reset(2);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (usrin != 4'd0) bad++;
      @(negedge clk);
    end
    chk("predbnc_usrin", bad, 0);
    do_reset(1);
    bad = 0;
    for (int k = 0; k < 48; k++) begin
      if (usrin != 4'd0 || keyev) bad++;
      @(negedge clk);
    end
    chk("postrst_hold", bad, 0);
    chk("postrst_usrin", int'(usrin), 8);
    chk("postrst_keyev", int'(keyev), 1);
    @(negedge clk);
    chk("postrst_keyev_end", int'(keyev), 0);
    mask = 16'h0000;
    window(80, p);
    chk("final_release_usrin", int'(usrin), 0);

    chk("keyev_width", consec, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
